// File: rtl/spi_status_out.sv
// SPI mode-0 slave transmitter: snapshots WORDS 16-bit status words on CS fall
// and shifts them out MSB first on MISO, oversampling the asynchronous SPI pins.
module spi_status_out #(
  parameter int WORDS       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_SPI_CS,
  input  logic                 i_SPI_Clock,
  output logic                 o_SPI_Data,
  input  logic [16*WORDS-1:0]  i_Words,
  output logic                 o_Frame_Sent,
  output logic                 o_Frame_Abort,
  output logic                 o_Busy
);

  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int FILL_W = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS - 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Pin synchronisers plus one history flop each for edge detection
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic                   cs_hist_q;
  logic                   sck_hist_q;
  logic                   cs_s;
  logic                   sck_s;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sck_fall;

  logic [FILL_W-1:0]      fill_q;
  logic                   suppress_q;

  state_t                 state_q;
  state_t                 state_d;
  logic [WIDX_W-1:0]      word_idx_q;
  logic [WIDX_W-1:0]      word_idx_d;
  logic [WIDX_W-1:0]      nxt_idx;
  logic [3:0]             bit_cnt_q;
  logic [3:0]             bit_cnt_d;
  logic                   miso_q;
  logic                   miso_d;
  logic                   sent_q;
  logic                   sent_d;
  logic                   abort_q;
  logic                   abort_d;
  logic                   busy_q;
  logic                   busy_d;
  logic                   load;
  logic [15:0]            cur_word;
  logic [15:0]            nxt_word;
  logic [15:0]            shadow_q [WORDS];

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      cs_sync_q  <= '1;
      sck_sync_q <= '0;
      cs_hist_q  <= 1'b1;
      sck_hist_q <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], i_SPI_Clock};
      cs_hist_q  <= cs_sync_q[SYNC_STAGES-1];
      sck_hist_q <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_fall  = cs_hist_q & ~cs_s;
  assign cs_rise  = ~cs_hist_q & cs_s;
  assign sck_fall = sck_hist_q & ~sck_s;

  // The CS synchroniser resets high, so a CS held low through reset looks like
  // a fresh fall once the pipe fills; only a genuine high sample re-arms starts.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      fill_q     <= '0;
      suppress_q <= 1'b1;
    end else begin
      if (fill_q != FILL_MAX) begin
        fill_q <= fill_q + 1'b1;
      end
      if ((fill_q == FILL_MAX) && cs_s) begin
        suppress_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      sent_q     <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      miso_q     <= miso_d;
      sent_q     <= sent_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (load) begin
      for (int k = 0; k < WORDS; k++) begin
        shadow_q[k] <= i_Words[16*k +: 16];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cs_fall && !suppress_q) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
        end else if (sck_fall && (bit_cnt_q == 4'd15) && (word_idx_q == LAST_WORD)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nxt_idx = (word_idx_q == LAST_WORD) ? word_idx_q : word_idx_q + 1'b1;
  end

  always_comb begin
    word_idx_d = word_idx_q;
    bit_cnt_d  = bit_cnt_q;
    miso_d     = miso_q;
    busy_d     = busy_q;
    sent_d     = 1'b0;
    abort_d    = 1'b0;
    load       = 1'b0;
    cur_word   = shadow_q[word_idx_q];
    nxt_word   = shadow_q[nxt_idx];
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall && !suppress_q) begin
          load       = 1'b1;
          word_idx_d = '0;
          bit_cnt_d  = '0;
          miso_d     = i_Words[15];
          busy_d     = 1'b1;
        end
      end
      SHIFT: begin
        // CS rise takes priority over a coincident SCK fall
        if (cs_rise) begin
          abort_d = 1'b1;
          busy_d  = 1'b0;
          miso_d  = 1'b0;
        end else if (sck_fall) begin
          if (bit_cnt_q != 4'd15) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            miso_d    = cur_word[4'd14 - bit_cnt_q];
          end else if (word_idx_q != LAST_WORD) begin
            word_idx_d = nxt_idx;
            bit_cnt_d  = '0;
            miso_d     = nxt_word[15];
          end else begin
            miso_d = 1'b0;
          end
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          sent_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: begin
        miso_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign o_SPI_Data    = miso_q;
  assign o_Frame_Sent  = sent_q;
  assign o_Frame_Abort = abort_q;
  assign o_Busy        = busy_q;

endmodule

// File: doc/spi_status_out.md
Name: spi_status_out

Overview:
- SPI slave transmitter on the MCU control link. It is the return path for the existing ADC SPI receiver.
- The MCU, as master, drives CS and SCK. This block shifts a snapshot of WORDS 16-bit status words out on MISO.
- Typical payload: Frequency, Harmonic_Count, Freq_Too_High flags, and a frame counter.
- Lives in the 48 MHz Main_Clock domain. SPI pins are asynchronous and are oversampled.

Parameters:
- WORDS, 4: number of 16-bit words per frame (1..8).
- SYNC_STAGES, 2: synchroniser depth for i_SPI_CS and i_SPI_Clock (≥2).

Ports:
- i_Clock, input, 1: Main_Clock, 48 MHz; all logic on its rising edge.
- i_Reset, input, 1: synchronous, active-high reset.
- i_SPI_CS, input, 1: chip select, active low, async.
- i_SPI_Clock, input, 1: SPI SCK, idle low (mode 0), async.
- o_SPI_Data, output, 1: MISO, MSB first.
- i_Words, input, 16*WORDS: status words; word k is at [16k+15:16k]; word 0 is sent first.
- o_Frame_Sent, output, 1: one-cycle pulse when CS rises after all 16*WORDS bits were shifted.
- o_Frame_Abort, output, 1: one-cycle pulse when CS rises with the frame incomplete.
- o_Busy, output, 1: high from CS-fall detection until CS-rise detection.

Behaviour:
- Reset values:
  - o_SPI_Data=0, o_Frame_Sent=0, o_Frame_Abort=0, o_Busy=0, state=IDLE.
  - All synchroniser flops reset: CS to 1, SCK to 0.
- Synchronisation and edge detection:
  - CS and SCK each pass through SYNC_STAGES flops.
  - Edges are detected on the last stage against one further history flop.
  - Supported SCK: ≤ i_Clock/8 (6 MHz); high and low phases each ≥4 i_Clock cycles.
- Mode 0 timing:
  - The master samples MISO on SCK rising edges. The block updates MISO after detected SCK falling edges.
  - MISO is a registered output.
  - Pin SCK fall to o_SPI_Data change: SYNC_STAGES+1 i_Clock cycles (3 at default).
- State IDLE:
  - o_SPI_Data=0.
  - On a detected CS falling edge:
    - snapshot i_Words into a shadow register in that same cycle;
    - word_idx=0, bit_cnt=0;
    - o_SPI_Data = word0[15] on the next cycle;
    - o_Busy=1; go to SHIFT.
  - Later changes on i_Words do not affect the frame in progress.
- State SHIFT, on a detected SCK falling edge:
  - If bit_cnt<15: bit_cnt+1 and output the next lower bit.
  - If bit_cnt==15 and word_idx<WORDS-1: word_idx+1, bit_cnt=0, output bit 15 of the next word.
  - If bit_cnt==15 and word_idx==WORDS-1: output 0, go to DONE.
- State DONE: further SCK edges are ignored; o_SPI_Data stays 0.
- CS rise:
  - From SHIFT: pulse o_Frame_Abort for 1 cycle.
  - From DONE: pulse o_Frame_Sent for 1 cycle.
  - In both cases: o_Busy=0, o_SPI_Data=0, go to IDLE.
- A CS rise seen in IDLE does nothing.
- Simultaneous CS rise and SCK fall in the same detection cycle: CS wins and no shift occurs.
- An SCK rising edge never changes state. An SCK fall while CS is high is ignored.
- Reset mid-frame:
  - Everything returns to reset values; no pulse is issued.
  - Because CS sync resets to 1, a CS held low through reset deasserts into a detected fall. Reset therefore also arms a flag that suppresses the next CS fall unless CS was seen high first.
  - Effect: a frame starts only after the first CS low-to-high-to-low sequence following reset.
- Frame length: exactly 16*WORDS SCK falling edges after the CS fall complete the frame.
  - The last data bit is sampled by the master on SCK rising edge 16*WORDS.
  - That is followed by falling edge 16*WORDS, which enters DONE.

Test Plan:
- Full frame:
  - Stimulus: WORDS=4, i_Words={16'h0004,16'hBEEF,16'h00FF,16'hA5C3}; CS low; 64 SCK pulses at 6 MHz; CS high.
  - Response: MISO sampled on SCK rises reads A5C3, 00FF, BEEF, 0004; o_Frame_Sent pulses once; o_Frame_Abort=0.
- Snapshot: change i_Words to 16'h1234 patterns 10 cycles after the CS fall -> the frame still carries the original values.
- Abort: CS high after 20 SCK pulses -> o_Frame_Abort pulses once, o_Frame_Sent=0, MISO=0. A following full frame is correct.
- Overclock: 70 SCK pulses in one frame -> bits 65..70 read 0; o_Frame_Sent pulses at CS rise.
- Reset with CS low:
  - Stimulus: reset asserted mid-frame at bit 30, CS still low, SCK continuing.
  - Response: MISO=0, no pulses. The next CS high-then-low frame delivers word0 MSB first.
- Latency: single SCK fall -> o_SPI_Data changes exactly 3 i_Clock cycles after the pin edge; first MSB is valid ≥4 cycles before the first SCK rise.
